// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave word engine oversampled by clk: MOSI deserialiser with valid/ready output,
// MISO serialiser fed from a valid/ready source. Inputs arrive already filtered in the clk domain.
module spi_slave_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  input  logic                  cs_n_i,
  output logic                  miso_o,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  underrun,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {SYNC = 2'd0, IDLE = 2'd1, ACTIVE = 2'd2} state_e;

  state_e                state_q, state_d;
  logic                  sclk_prev_q;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  load_pending_q, load_pending_d;
  logic                  miso_q, miso_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rise, fall, do_load;

  assign rise = sclk_i & ~sclk_prev_q;
  assign fall = ~sclk_i & sclk_prev_q;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    load_pending_d = load_pending_q;
    miso_d         = miso_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q;
    overrun_d      = 1'b0;
    underrun_d     = 1'b0;
    frame_err_d    = 1'b0;
    tx_ready       = 1'b0;
    do_load        = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      SYNC: begin
        // Never join a frame already in progress when coming out of reset.
        if (cs_n_i) state_d = IDLE;
      end
      IDLE: begin
        bit_cnt_d      = '0;
        load_pending_d = 1'b0;
        if (!cs_n_i) begin
          do_load = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_n_i) begin
          state_d        = IDLE;
          bit_cnt_d      = '0;
          rx_shift_d     = '0;
          load_pending_d = 1'b0;
          frame_err_d    = (bit_cnt_q != '0);
        end else if (rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_i};
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            bit_cnt_d      = '0;
            load_pending_d = 1'b1;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_i};
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (fall) begin
          // The next word is fetched on the fall that follows the last sampling rise.
          if (load_pending_q) begin
            do_load        = 1'b1;
            load_pending_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[DATA_WIDTH-2];
          end
        end
      end
      default: state_d = SYNC;
    endcase

    if (do_load) begin
      if (tx_valid) begin
        tx_shift_d = tx_data;
        miso_d     = tx_data[DATA_WIDTH-1];
        tx_ready   = 1'b1;
      end else begin
        tx_shift_d = '0;
        miso_d     = 1'b0;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SYNC;
      sclk_prev_q    <= 1'b0;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      load_pending_q <= 1'b0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      overrun_q      <= 1'b0;
      underrun_q     <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sclk_prev_q    <= sclk_i;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      load_pending_q <= load_pending_d;
      miso_q         <= miso_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      overrun_q      <= overrun_d;
      underrun_q     <= underrun_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign miso_o    = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = (state_q == ACTIVE);
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: mode-0 frames driven at 4 clk per sclk phase.
module tb_spi_slave_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_i, mosi_i, cs_n_i;
  logic       miso_o;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       busy, overrun, underrun, frame_err;

  int checks   = 0;
  int failures = 0;
  int tx_ready_cnt = 0, overrun_cnt = 0, underrun_cnt = 0, frame_err_cnt = 0;
  logic [7:0] rxq[$];

  spi_slave_shifter #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .sclk_i(sclk_i), .mosi_i(mosi_i), .cs_n_i(cs_n_i),
    .miso_o(miso_o), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .overrun(overrun), .underrun(underrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Event monitors sample mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (tx_ready)            tx_ready_cnt++;
    if (overrun)             overrun_cnt++;
    if (underrun)            underrun_cnt++;
    if (frame_err)           frame_err_cnt++;
    if (rx_valid && rx_ready) rxq.push_back(rx_data);
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shifts n bits of m MSB first; got collects miso_o as the master samples it on each rise.
  task automatic send_bits(input logic [7:0] m, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi_i = m[i];
      tick(4);
      got[i] = miso_o;
      sclk_i = 1'b1;
      tick(4);
      sclk_i = 1'b0;
    end
    tick(4);
  endtask

  initial begin
    logic [7:0] g1, g2;
    int b_tr, b_ov, b_ur, b_fe;

    rst = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0; cs_n_i = 1'b1;
    rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    tick(3);
    chk("rst_miso", 32'(miso_o), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tx_ready", 32'(tx_ready), 32'h0);
    chk("rst_pulses", 32'({overrun, underrun, frame_err}), 32'h0);
    rst = 1'b0;
    tick(3);

    // Single frame: rx 0xA5, tx 0x3C, source offers exactly one word.
    b_tr = tx_ready_cnt;
    tx_data = 8'h3C; tx_valid = 1'b1; cs_n_i = 1'b0;
    tick(1);
    chk("t1_tx_ready_once", 32'(tx_ready_cnt - b_tr), 32'd1);
    tx_valid = 1'b0;
    chk("t1_busy", 32'(busy), 32'h1);
    tick(3);
    send_bits(8'hA5, 8, g1);
    chk("t1_miso_bits", 32'(g1), 32'h3C);
    chk("t1_rx_valid", 32'(rx_valid), 32'h1);
    chk("t1_rx_data", 32'(rx_data), 32'hA5);
    cs_n_i = 1'b1;
    tick(3);
    chk("t1_tx_ready_total", 32'(tx_ready_cnt - b_tr), 32'd1);
    chk("t1_no_frame_err", 32'(frame_err_cnt), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    rx_ready = 1'b1;
    tick(1);
    chk("t1_consume", 32'(rx_valid), 32'h0);

    // Back-to-back words with a ready consumer; second tx word loads after the 8th rise.
    rxq.delete();
    b_tr = tx_ready_cnt;
    tx_data = 8'h81; tx_valid = 1'b1; cs_n_i = 1'b0;
    tick(1);
    tx_data = 8'h7E;
    tick(3);
    send_bits(8'h12, 8, g1);
    send_bits(8'h34, 8, g2);
    cs_n_i = 1'b1;
    tick(3);
    tx_valid = 1'b0;
    chk("t2_rx_count", 32'(rxq.size()), 32'd2);
    chk("t2_rx_word0", 32'(rxq[0]), 32'h12);
    chk("t2_rx_word1", 32'(rxq[1]), 32'h34);
    chk("t2_miso_word0", 32'(g1), 32'h81);
    chk("t2_miso_word1", 32'(g2), 32'h7E);
    chk("t2_tx_ready_cnt", 32'(tx_ready_cnt - b_tr), 32'd3);

    // Consumer stalled: second word dropped.
    rx_ready = 1'b0;
    b_ov = overrun_cnt;
    cs_n_i = 1'b0;
    tick(4);
    send_bits(8'h12, 8, g1);
    send_bits(8'h34, 8, g2);
    chk("t3_rx_data_kept", 32'(rx_data), 32'h12);
    chk("t3_rx_valid", 32'(rx_valid), 32'h1);
    chk("t3_overrun_once", 32'(overrun_cnt - b_ov), 32'd1);
    cs_n_i = 1'b1;
    tick(3);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("t3_consume", 32'(rx_valid), 32'h0);

    // Frame aborted after 5 bits, then a clean 0xFF frame.
    b_fe = frame_err_cnt;
    cs_n_i = 1'b0;
    tick(4);
    send_bits(8'hF0, 5, g1);
    cs_n_i = 1'b1;
    tick(3);
    chk("t4_frame_err", 32'(frame_err_cnt - b_fe), 32'd1);
    chk("t4_no_rx_valid", 32'(rx_valid), 32'h0);
    chk("t4_busy", 32'(busy), 32'h0);
    cs_n_i = 1'b0;
    tick(4);
    send_bits(8'hFF, 8, g1);
    cs_n_i = 1'b1;
    tick(3);
    chk("t4_rx_ff", 32'(rx_data), 32'hFF);
    chk("t4_rx_valid", 32'(rx_valid), 32'h1);
    chk("t4_no_new_frame_err", 32'(frame_err_cnt - b_fe), 32'd1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;

    // Empty tx source: zeros on MISO, reception unaffected.
    b_ur = underrun_cnt;
    tx_valid = 1'b0;
    cs_n_i = 1'b0;
    tick(4);
    chk("t5_underrun", 32'(underrun_cnt - b_ur), 32'd1);
    send_bits(8'hA3, 8, g1);
    chk("t5_miso_zero", 32'(g1), 32'h00);
    cs_n_i = 1'b1;
    tick(3);
    chk("t5_rx_data", 32'(rx_data), 32'hA3);
    chk("t5_rx_valid", 32'(rx_valid), 32'h1);

    // Reset mid-frame with cs_n held low.
    tx_data = 8'hFF; tx_valid = 1'b1;
    cs_n_i = 1'b0;
    tick(4);
    chk("t6_pre_miso", 32'(miso_o), 32'h1);
    send_bits(8'hF0, 3, g1);
    rst = 1'b1;
    tick(2);
    chk("t6_rst_miso", 32'(miso_o), 32'h0);
    chk("t6_rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("t6_rst_rx_data", 32'(rx_data), 32'h00);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(2);
    send_bits(8'h99, 8, g1);
    chk("t6_ignored_rx_valid", 32'(rx_valid), 32'h0);
    chk("t6_ignored_busy", 32'(busy), 32'h0);
    chk("t6_ignored_rx_data", 32'(rx_data), 32'h00);
    cs_n_i = 1'b1;
    tick(3);
    cs_n_i = 1'b0;
    tick(4);
    send_bits(8'h5A, 8, g1);
    cs_n_i = 1'b1;
    tick(3);
    chk("t6_rx_5a", 32'(rx_data), 32'h5A);
    chk("t6_rx_valid", 32'(rx_valid), 32'h1);
    chk("t6_miso_ff", 32'(g1), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
